qspi_psram_target: RTL

Synthesizable QSPI/SPI PSRAM responder for the far side of our AHB-to-QSPI controller: decodes the command set that controller issues and serves reads and writes from a byte-wide local memory port. It is used as an FPGA-side PSRAM stand-in and as a loopback target in system benches. All pins are oversampled on one system clock; the SPI clock is never used as a clock.

---
 rtl/qspi_psram_target.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/qspi_psram_target.sv
// QSPI/SPI PSRAM responder: oversamples csn/sck/IO on the system clock and serves a byte-wide memory port.
// Optional QPI support is compiled in when QSPI_TARGET_QUAD_EN is defined; otherwise only SPI 0x0B/0x02 exist.
module qspi_psram_target #(
  parameter int ADDR_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 csn,
  input  logic                 sck,
  input  logic [3:0]           data_i,
  output logic [3:0]           data_o,
  output logic [3:0]           data_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic                 quad_mode
);

`ifdef QSPI_TARGET_QUAD_EN
  localparam logic QUAD_EN = 1'b1;
`else
  localparam logic QUAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0]      csn_sync;
  logic [SYNC_STAGES-1:0]      sck_sync;
  logic [SYNC_STAGES-1:0][3:0] data_sync;
  logic                        sck_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csn_sync  <= '1;
      sck_sync  <= '0;
      data_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      data_sync <= {data_sync[SYNC_STAGES-2:0], data_i};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic       csn_s;
  logic       rise;
  logic       fall;
  logic [3:0] din;
  assign csn_s = csn_sync[SYNC_STAGES-1];
  assign rise  = sck_sync[SYNC_STAGES-1] & ~sck_prev;
  assign fall  = ~sck_sync[SYNC_STAGES-1] & sck_prev;
  assign din   = data_sync[SYNC_STAGES-1];

  state_t      state;
  logic [4:0]  cnt;
  logic [7:0]  shift_in;
  logic [23:0] addr_reg;
  logic        is_read;
  logic [7:0]  dout_shift;
  logic [7:0]  rd_byte;
  logic        rd_pending;

  logic [4:0]  step;
  logic [4:0]  cnt_nx;
  logic [4:0]  dummy_len;
  logic [7:0]  shift_nx;
  logic [23:0] addr_nx;
  logic [23:0] addr_inc;
  logic [7:0]  src_byte;
  logic        rd_cmd;
  logic        wr_cmd;

  always_comb begin
    step      = quad_mode ? 5'd4 : 5'd1;
    cnt_nx    = cnt + step;
    dummy_len = quad_mode ? 5'd6 : 5'd8;
    shift_nx  = quad_mode ? {shift_in[3:0], din} : {shift_in[6:0], din[0]};
    addr_nx   = quad_mode ? {addr_reg[19:0], din} : {addr_reg[22:0], din[0]};
    addr_inc  = addr_reg + 24'd1;
    // The first unit of every byte comes from the prefetched byte, the rest from the shifter.
    src_byte  = (cnt == 5'd0) ? rd_byte : dout_shift;
    rd_cmd    = quad_mode ? (shift_nx == 8'hEB) : (shift_nx == 8'h0B);
    wr_cmd    = quad_mode ? (shift_nx == 8'h38) : (shift_nx == 8'h02);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_in   <= '0;
      addr_reg   <= '0;
      is_read    <= 1'b0;
      dout_shift <= '0;
      rd_byte    <= '0;
      rd_pending <= 1'b0;
      data_o     <= '0;
      data_oe    <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      quad_mode  <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      rd_pending <= mem_re;
      if (rd_pending)
        rd_byte <= mem_rdata;

      // Deselect overrides any sck edge seen on the same clock.
      if (csn_s) begin
        state   <= IDLE;
        cnt     <= '0;
        data_o  <= '0;
        data_oe <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= CMD;
            cnt   <= '0;
          end
          CMD: if (rise) begin
            shift_in <= shift_nx;
            if (cnt_nx == 5'd8) begin
              cnt <= '0;
              if (shift_nx == 8'h35) begin
                quad_mode <= QUAD_EN;
                state     <= IGNORE;
              end else if (shift_nx == 8'hF5) begin
                quad_mode <= 1'b0;
                state     <= IGNORE;
              end else if (rd_cmd) begin
                is_read <= 1'b1;
                state   <= ADDR;
              end else if (wr_cmd) begin
                is_read <= 1'b0;
                state   <= ADDR;
              end else begin
                state <= IGNORE;
              end
            end else begin
              cnt <= cnt_nx;
            end
          end
          ADDR: if (rise) begin
            addr_reg <= addr_nx;
            if (cnt_nx == 5'd24) begin
              cnt <= '0;
              if (is_read) begin
                mem_re   <= 1'b1;
                mem_addr <= addr_nx[ADDR_BITS-1:0];
                state    <= DUMMY;
              end else begin
                state <= WDATA;
              end
            end else begin
              cnt <= cnt_nx;
            end
          end
          DUMMY: if (rise) begin
            if (cnt + 5'd1 == dummy_len) begin
              cnt   <= '0;
              state <= RDATA;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          RDATA: if (fall) begin
            data_oe    <= quad_mode ? 4'b1111 : 4'b0010;
            data_o     <= quad_mode ? src_byte[7:4] : {2'b00, src_byte[7], 1'b0};
            dout_shift <= quad_mode ? {src_byte[3:0], 4'b0000} : {src_byte[6:0], 1'b0};
            cnt        <= (cnt_nx == 5'd8) ? 5'd0 : cnt_nx;
            // Fetch the following byte while this one is still being shifted out.
            if (cnt == 5'd0) begin
              mem_re   <= 1'b1;
              addr_reg <= addr_inc;
              mem_addr <= addr_inc[ADDR_BITS-1:0];
            end
          end
          WDATA: if (rise) begin
            shift_in <= shift_nx;
            if (cnt_nx == 5'd8) begin
              cnt       <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= shift_nx;
              mem_addr  <= addr_reg[ADDR_BITS-1:0];
              addr_reg  <= addr_inc;
            end else begin
              cnt <= cnt_nx;
            end
          end
          IGNORE: begin
            data_oe <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
